mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the 16-bit pipeline.
- Consumes the EXE/MEM register outputs: write-enable, read/write memory enables, store data, destination and ALU result.
- Performs loads and stores to the data memory over a req/ack handshake, stalling upstream while an access is pending.
- Presents a registered writeback bundle to the register file.

Parameters:
ARQ, 16, datapath width (data, ALU result, destination field)
MEMORY_ADDR_SIZE, 13, data-memory address width; address = alu_result_in[MEMORY_ADDR_SIZE-1:0]
MAX_WAIT, 8, max ACCESS cycles waiting for mem_ack before timeout (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  EXE/MEM bundle holds a valid op this cycle
wb_en_in  in  1  op writes back to the register file
rd_mem_en_in  in  1  op is a load
wr_mem_en_in  in  1  op is a store
sr1_in  in  ARQ  store data
srdest_in  in  ARQ  destination register field
alu_result_in  in  ARQ  ALU result or memory address
stall  out  1  upstream must hold its bundle (combinational = state==ACCESS)
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = store, 0 = load
mem_addr  out  MEMORY_ADDR_SIZE  memory address
mem_wdata  out  ARQ  store data
mem_rdata  in  ARQ  load data, valid with mem_ack
mem_ack  in  1  memory completes the request this cycle
wb_valid  out  1  writeback bundle valid (1-cycle pulse per op)
wb_en  out  1  register-file write enable
wb_dest  out  ARQ  destination field
wb_data  out  ARQ  writeback data
timeout_err  out  1  sticky; memory failed to ack within MAX_WAIT
illegal_err  out  1  1-cycle pulse; rd_mem_en_in and wr_mem_en_in both set

Behaviour:
- Reset (rst=0, async): state IDLE; every output and internal register = 0; timeout_err cleared; an in-flight mem_req drops immediately.
- Reset mid-access: the access is abandoned with no writeback. The memory side tolerates a dropped request.
- FSM states: IDLE and ACCESS.
- IDLE: samples in_valid at each rising edge; stall=0.
  - ALU op (rd=0, wr=0): next cycle wb_valid=1, wb_en=wb_en_in, wb_dest=srdest_in, wb_data=alu_result_in. Stay IDLE. Latency 1, back-to-back ops every cycle.
  - Load: latch addr and dest, go to ACCESS. mem_req=1 and mem_we=0 registered from the next cycle.
  - Store: latch addr and wdata=sr1_in, go to ACCESS. mem_req=1 and mem_we=1.
  - rd=1 and wr=1: no memory access. Next cycle illegal_err=1 and wb_valid=1 with wb_en=0. Stay IDLE.
- ACCESS:
  - stall=1; mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - A wait counter starts at 1 on the first ACCESS cycle and increments each cycle without ack.
  - mem_ack=1 at an edge: mem_req=0 next cycle; state to IDLE; wb_valid=1 next cycle.
    - Load: wb_data=mem_rdata sampled at that edge, wb_en=wb_en_in latched.
    - Store: wb_en=0, wb_data=0.
  - Counter==MAX_WAIT with no ack: drop mem_req; timeout_err=1 (sticky until reset); wb_valid=1, wb_en=0; state to IDLE.
  - Ack on the MAX_WAIT-th cycle counts as success, not timeout.
- Latency: load acked on the first ACCESS cycle (T+1) gives wb_valid at T+2, and stall is high only in T+1.
- While stall=0 in the cycle after ack, a new op is accepted in the same cycle that wb_valid is asserted.
- mem_ack while IDLE is ignored. in_valid is ignored while in ACCESS; upstream holds its bundle.
- wb_valid, wb_en and illegal_err are 1-cycle pulses, 0 otherwise. wb_dest and wb_data hold their last value when wb_valid=0.
- The address uses the low MEMORY_ADDR_SIZE bits of alu_result_in; the upper bits are ignored with no error.

Test Plan:
- Reset then ALU op alu_result_in=0x1234, srdest=5, wb_en_in=1 -> next cycle wb_valid=1, wb_en=1, wb_dest=5, wb_data=0x1234; stall never 1; mem_req stays 0.
- Load at alu_result_in=0xE00A, ack after 3 cycles with mem_rdata=0xBEEF -> mem_addr=0x000A, mem_we=0, stall=1 for 3 cycles, then wb_data=0xBEEF, wb_en=1.
- Store sr1_in=0x00FF to addr 0x0010, ack in first cycle -> mem_we=1, mem_wdata=0x00FF, stall 1 cycle, wb_valid=1 with wb_en=0.
- Load with MAX_WAIT=8 and no ack -> mem_req drops after 8 cycles; timeout_err=1 and holds; wb_en=0. A second run with ack on cycle 8 completes normally.
- rd_mem_en_in=wr_mem_en_in=1 -> illegal_err pulse, no mem_req, wb_en=0. Drive rst=0 mid-ACCESS -> mem_req=0 immediately and no wb_valid after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: ALU results pass straight through, while loads and stores
// go to data memory over a req/ack handshake with a bounded wait and a registered writeback bundle.
module mem_wb_stage #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int MAX_WAIT         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        wb_en_in,
  input  logic                        rd_mem_en_in,
  input  logic                        wr_mem_en_in,
  input  logic [ARQ-1:0]              sr1_in,
  input  logic [ARQ-1:0]              srdest_in,
  input  logic [ARQ-1:0]              alu_result_in,
  output logic                        stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [ARQ-1:0]              mem_wdata,
  input  logic [ARQ-1:0]              mem_rdata,
  input  logic                        mem_ack,
  output logic                        wb_valid,
  output logic                        wb_en,
  output logic [ARQ-1:0]              wb_dest,
  output logic [ARQ-1:0]              wb_data,
  output logic                        timeout_err,
  output logic                        illegal_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_cnt;
  logic [ARQ-1:0] pend_dest;
  logic           pend_wb_en;

  logic op_alu, op_load, op_store, op_illegal;
  logic wait_last, access_done;

  // Upper address bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^alu_result_in[ARQ-1:MEMORY_ADDR_SIZE];

  assign op_alu     = ~rd_mem_en_in & ~wr_mem_en_in;
  assign op_load    =  rd_mem_en_in & ~wr_mem_en_in;
  assign op_store   = ~rd_mem_en_in &  wr_mem_en_in;
  assign op_illegal =  rd_mem_en_in &  wr_mem_en_in;

  assign wait_last   = (wait_cnt == CW'(MAX_WAIT));
  assign access_done = (state_q == ACCESS) && (mem_ack || wait_last);
  assign stall       = (state_q == ACCESS);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && (op_load || op_store)) state_d = ACCESS;
      ACCESS:  if (access_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      pend_dest   <= '0;
      pend_wb_en  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_dest     <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the
      // branch that produces a writeback; there is no separate clear path.
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      illegal_err <= 1'b0;

      if (state_q == IDLE) begin
        if (in_valid) begin
          if (op_alu) begin
            wb_valid <= 1'b1;
            wb_en    <= wb_en_in;
            wb_dest  <= srdest_in;
            wb_data  <= alu_result_in;
          end else if (op_illegal) begin
            wb_valid    <= 1'b1;
            wb_dest     <= srdest_in;
            wb_data     <= '0;
            illegal_err <= 1'b1;
          end else begin
            mem_req    <= 1'b1;
            mem_we     <= op_store;
            mem_addr   <= alu_result_in[MEMORY_ADDR_SIZE-1:0];
            if (op_store) mem_wdata <= sr1_in;
            pend_dest  <= srdest_in;
            pend_wb_en <= wb_en_in;
            wait_cnt   <= CW'(1);
          end
        end
      end else begin
        if (mem_ack) begin
          // Ack on the final permitted cycle still counts as success.
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          wb_dest  <= pend_dest;
          wb_en    <= mem_we ? 1'b0 : pend_wb_en;
          wb_data  <= mem_we ? '0 : mem_rdata;
        end else if (wait_last) begin
          mem_req     <= 1'b0;
          timeout_err <= 1'b1;
          wb_valid    <= 1'b1;
          wb_dest     <= pend_dest;
          wb_data     <= '0;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule
